// File: rtl/core_id_stage.sv
// RV32I instruction-decode stage: decodes fields and immediate, reads the
// 32x32 register file (write port driven by writeback) and registers one
// operand bundle per accepted instruction for the ALU stage.
//
// Ports:
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_if_valid/i_if_instr/i_if_pc, o_if_ready
//                               fetch handshake and instruction
//   i_flush                     drop held and incoming instruction
//   i_wb_en/i_wb_rd/i_wb_data   register-file write port
//   o_ex_valid, i_ex_ready      ALU-side handshake
//   o_opcode/o_funct7/o_funct3/o_rd/o_num1u/o_num2u/o_pc/o_immu/o_illegal
//                               registered operand bundle
//
// Optional feature: define CORE_ID_BYPASS_EN to forward same-cycle
// writeback into captured operands and to refresh operands of a held bundle.
module core_id_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_valid,
    input  logic [31:0] i_if_instr,
    input  logic [31:0] i_if_pc,
    output logic        o_if_ready,
    input  logic        i_flush,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic        o_ex_valid,
    input  logic        i_ex_ready,
    output logic [6:0]  o_opcode,
    output logic [6:0]  o_funct7,
    output logic [2:0]  o_funct3,
    output logic [4:0]  o_rd,
    output logic [31:0] o_num1u,
    output logic [31:0] o_num2u,
    output logic [31:0] o_pc,
    output logic [31:0] o_immu,
    output logic        o_illegal
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] rf [32];

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        capture;
    logic        wb_write;

    assign opcode   = i_if_instr[6:0];
    assign rs1      = i_if_instr[19:15];
    assign rs2      = i_if_instr[24:20];
    assign wb_write = i_wb_en && (i_wb_rd != 5'd0);

    assign o_if_ready = !o_ex_valid || i_ex_ready;
    assign capture    = i_if_valid && o_if_ready && !i_flush;

    // Immediate generation; R-type is legal but carries no immediate.
    always_comb begin
        imm     = 32'd0;
        illegal = 1'b0;
        if (i_if_instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OP_IMM, OP_LOAD, OP_JALR:
                    imm = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
                OP_STORE:
                    imm = {{20{i_if_instr[31]}}, i_if_instr[31:25],
                           i_if_instr[11:7]};
                OP_BRANCH:
                    imm = {{19{i_if_instr[31]}}, i_if_instr[31],
                           i_if_instr[7], i_if_instr[30:25],
                           i_if_instr[11:8], 1'b0};
                OP_LUI, OP_AUIPC:
                    imm = {i_if_instr[31:12], 12'd0};
                OP_JAL:
                    imm = {{11{i_if_instr[31]}}, i_if_instr[31],
                           i_if_instr[19:12], i_if_instr[20],
                           i_if_instr[30:21], 1'b0};
                OP_REG:
                    imm = 32'd0;
                default:
                    illegal = 1'b1;
            endcase
        end
    end

    // Register reads; the bypass path forwards a writeback landing on
    // the same edge as the capture.
    always_comb begin
        rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
        rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
`ifdef CORE_ID_BYPASS_EN
        if (wb_write && (i_wb_rd == rs1))
            rs1_val = i_wb_data;
        if (wb_write && (i_wb_rd == rs2))
            rs2_val = i_wb_data;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'd0;
        end else if (wb_write) begin
            rf[i_wb_rd] <= i_wb_data;
        end
    end

`ifdef CORE_ID_BYPASS_EN
    logic [4:0] rs1_q;
    logic [4:0] rs2_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ex_valid <= 1'b0;
            o_opcode   <= 7'd0;
            o_funct7   <= 7'd0;
            o_funct3   <= 3'd0;
            o_rd       <= 5'd0;
            o_num1u    <= 32'd0;
            o_num2u    <= 32'd0;
            o_pc       <= 32'd0;
            o_immu     <= 32'd0;
            o_illegal  <= 1'b0;
`ifdef CORE_ID_BYPASS_EN
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
`endif
        end else if (i_flush) begin
            o_ex_valid <= 1'b0;
        end else if (capture) begin
            o_ex_valid <= 1'b1;
            o_opcode   <= opcode;
            o_funct7   <= i_if_instr[31:25];
            o_funct3   <= i_if_instr[14:12];
            o_rd       <= i_if_instr[11:7];
            o_num1u    <= rs1_val;
            o_num2u    <= rs2_val;
            o_pc       <= i_if_pc;
            o_immu     <= imm;
            o_illegal  <= illegal;
`ifdef CORE_ID_BYPASS_EN
            rs1_q      <= rs1;
            rs2_q      <= rs2;
`endif
        end else if (o_ex_valid && i_ex_ready) begin
            o_ex_valid <= 1'b0;
        end else if (o_ex_valid) begin
`ifdef CORE_ID_BYPASS_EN
            // Held bundle picks up writebacks to its source registers.
            if (wb_write && (i_wb_rd == rs1_q))
                o_num1u <= i_wb_data;
            if (wb_write && (i_wb_rd == rs2_q))
                o_num2u <= i_wb_data;
`endif
        end
    end

endmodule

// File: tb/tb_core_id_stage.sv
// Directed testbench for core_id_stage.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_core_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] num1u;
    logic [31:0] num2u;
    logic [31:0] pc;
    logic [31:0] immu;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_id_stage dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_if_valid (if_valid),
        .i_if_instr (if_instr),
        .i_if_pc    (if_pc),
        .o_if_ready (if_ready),
        .i_flush    (flush),
        .i_wb_en    (wb_en),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_ex_valid (ex_valid),
        .i_ex_ready (ex_ready),
        .o_opcode   (opcode),
        .o_funct7   (funct7),
        .o_funct3   (funct3),
        .o_rd       (rd),
        .o_num1u    (num1u),
        .o_num2u    (num2u),
        .o_pc       (pc),
        .o_immu     (immu),
        .o_illegal  (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        if_valid = 1'b0;
        if_instr = 32'd0;
        if_pc    = 32'd0;
        flush    = 1'b0;
        wb_en    = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = 32'd0;
        ex_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_imm", immu, 32'd0);
        chk("rst_num1", num1u, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ready", {31'd0, if_ready}, 32'd1);

        // ADDI x1,x0,-5
        if_valid = 1'b1;
        if_instr = 32'hFFB00093;
        if_pc    = 32'h100;
        step();
        chk("addi_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi_op", {25'd0, opcode}, 32'h13);
        chk("addi_imm", immu, 32'hFFFFFFFB);
        chk("addi_num1", num1u, 32'd0);
        chk("addi_pc", pc, 32'h100);
        chk("addi_rd", {27'd0, rd}, 32'd1);

        // Write x5, attempt write to x0
        if_valid = 1'b0;
        wb_en    = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'h1234;
        step();
        chk("drain_valid", {31'd0, ex_valid}, 32'd0);
        chk("drain_pc_hold", pc, 32'h100);
        wb_rd   = 5'd0;
        wb_data = 32'hDEAD;
        step();
        wb_en = 1'b0;

        // ADD x3,x5,x5
        if_valid = 1'b1;
        if_instr = 32'h005281B3;
        if_pc    = 32'h104;
        step();
        chk("add_num1", num1u, 32'h1234);
        chk("add_num2", num2u, 32'h1234);
        chk("add_f7", {25'd0, funct7}, 32'd0);
        chk("add_rd", {27'd0, rd}, 32'd3);
        chk("add_illegal", {31'd0, illegal}, 32'd0);

        // ADD x4,x0,x0 : x0 must still read zero
        if_instr = 32'h00000233;
        if_pc    = 32'h108;
        step();
        chk("x0_num1", num1u, 32'd0);
        chk("x0_num2", num2u, 32'd0);
        chk("x0_rd", {27'd0, rd}, 32'd4);

        // Stall three cycles with ADDI x2,x5,1 pending
        ex_ready = 1'b0;
        if_instr = 32'h00128113;
        if_pc    = 32'h10C;
        #1;
        chk("stall_ready", {31'd0, if_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
            chk("stall_rd", {27'd0, rd}, 32'd4);
            chk("stall_pc", pc, 32'h108);
            chk("stall_ready2", {31'd0, if_ready}, 32'd0);
        end
        ex_ready = 1'b1;
        #1;
        chk("release_ready", {31'd0, if_ready}, 32'd1);
        step();
        chk("rel1_rd", {27'd0, rd}, 32'd2);
        chk("rel1_num1", num1u, 32'h1234);
        chk("rel1_imm", immu, 32'd1);
        chk("rel1_pc", pc, 32'h10C);
        // ADDI x6,x0,7 next cycle
        if_instr = 32'h00700313;
        if_pc    = 32'h110;
        step();
        chk("rel2_rd", {27'd0, rd}, 32'd6);
        chk("rel2_imm", immu, 32'd7);
        chk("rel2_valid", {31'd0, ex_valid}, 32'd1);

        // Immediate formats
        if_instr = 32'hFE000EE3;
        step();
        chk("beq_imm", immu, 32'hFFFFFFFC);
        chk("beq_op", {25'd0, opcode}, 32'h63);
        if_instr = 32'h0080006F;
        step();
        chk("jal_imm", immu, 32'h8);
        if_instr = 32'h12345037;
        step();
        chk("lui_imm", immu, 32'h12345000);
        if_instr = 32'hFE502E23;
        step();
        chk("sw_imm", immu, 32'hFFFFFFFC);
        chk("sw_num2", num2u, 32'h1234);
        if_instr = 32'h0000007F;
        step();
        chk("bad_illegal", {31'd0, illegal}, 32'd1);
        chk("bad_imm", immu, 32'd0);
        chk("bad_valid", {31'd0, ex_valid}, 32'd1);
        if_instr = 32'h00000010;
        step();
        chk("low_illegal", {31'd0, illegal}, 32'd1);
        if_instr = 32'h00000013;
        step();
        chk("nop_illegal", {31'd0, illegal}, 32'd0);

        // Flush with held bundle and incoming instruction
        ex_ready = 1'b0;
        flush    = 1'b1;
        if_instr = 32'h00100093;
        step();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        flush    = 1'b0;
        if_valid = 1'b0;
        ex_ready = 1'b1;
        step();
        chk("flush_nocap", {31'd0, ex_valid}, 32'd0);

        // Writeback forwarding: x7 = 0x11 first
        wb_en   = 1'b1;
        wb_rd   = 5'd7;
        wb_data = 32'h11;
        step();
        // ADD x8,x7,x0 captured while x7 <= 0xAA
        if_valid = 1'b1;
        if_instr = 32'h00038433;
        wb_data  = 32'hAA;
        step();
        wb_en = 1'b0;
`ifdef CORE_ID_BYPASS_EN
        chk("byp_same", num1u, 32'hAA);
`else
        chk("byp_same", num1u, 32'h11);
`endif
        // ADD x9,x0,x7 captured, then held while x7 <= 0xBB
        if_instr = 32'h007004B3;
        step();
        chk("byp_cap2", num2u, 32'hAA);
        ex_ready = 1'b0;
        if_valid = 1'b0;
        wb_en    = 1'b1;
        wb_data  = 32'hBB;
        step();
        wb_en = 1'b0;
`ifdef CORE_ID_BYPASS_EN
        chk("byp_held", num2u, 32'hBB);
`else
        chk("byp_held", num2u, 32'hAA);
`endif
        chk("byp_held_v", {31'd0, ex_valid}, 32'd1);

        // Reset while holding a bundle, with flush also asserted
        rst   = 1'b1;
        flush = 1'b1;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        chk("mrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mrst_num2", num2u, 32'd0);
        chk("mrst_ready", {31'd0, if_ready}, 32'd1);
        // ADD x10,x5,x0 : registers were cleared
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h00028533;
        step();
        chk("mrst_x5", num1u, 32'd0);
        chk("mrst_rd", {27'd0, rd}, 32'd10);
        if_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
